// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bus between a requester and the nibble-serial adder controller.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 4 * WORDS;

    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    // Requester side: issues operations, consumes the result.
    modport master (
        output start, op, a, b,
        input  ready, busy, done, sum, cout, ovf
    );

    // Controller side.
    modport slave (
        input  start, op, a, b,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller: one shared 4-bit ripple adder, LS nibble first,
// inter-nibble carry kept in a register, registered result with a one-cycle done pulse.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int unsigned W      = 4 * WORDS;
    localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned BASE_W = IDX_W + 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic               w_ready_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [W-1:0]       r_a_lat;
    logic [W-1:0]       r_b_eff;
    logic               r_c;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_work;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [BASE_W-1:0]  w_base;
    logic [3:0]         w_nib_x;
    logic [3:0]         w_nib_y;
    logic [3:0]         w_nib_sum;
    logic               w_nib_cout;
    logic [W-1:0]       w_work_nxt;
    logic               w_ovf;

    assign w_accept = bus.start && r_ready;
    assign w_last   = (r_idx == IDX_LAST);
    assign w_base   = {r_idx, 2'b00};
    assign w_nib_x  = r_a_lat[w_base +: 4];
    assign w_nib_y  = r_b_eff[w_base +: 4];

    // The single shared nibble adder.
    Ripple_Carry_Adder_4bit u_rca (
        .i_x    (w_nib_x),
        .i_y    (w_nib_y),
        .i_cin  (r_c),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // Working value with the current nibble merged in; on the last nibble this is the result.
    always_comb begin
        w_work_nxt                = r_work;
        w_work_nxt[w_base +: 4]   = w_nib_sum;
    end

    // Signed overflow: operands of equal sign producing a result of the other sign.
    assign w_ovf = (r_a_lat[W-1] == r_b_eff[W-1]) && (w_work_nxt[W-1] != r_a_lat[W-1]);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the next state so they can be registered.
    always_comb begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_RUN: begin
                w_ready_nxt = 1'b0;
                w_busy_nxt  = 1'b1;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Operand capture, nibble stepping and result update on the final nibble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_lat <= '0;
            r_b_eff <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_lat <= bus.a;
            r_b_eff <= bus.op ? ~bus.b : bus.b;
            r_c     <= bus.op;
            r_idx   <= '0;
            r_work  <= '0;
        end else if (r_state == S_RUN) begin
            r_work  <= w_work_nxt;
            r_c     <= w_nib_cout;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_sum  <= w_work_nxt;
                r_cout <= w_nib_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum   = r_sum;
    assign bus.cout  = r_cout;
    assign bus.ovf   = r_ovf;
endmodule

// 4-bit ripple-carry adder shared by the controller.
module Ripple_Carry_Adder_4bit (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_c;

    // Bit-by-bit full-adder chain.
    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < 4; i++) begin
            o_sum[i]  = i_x[i] ^ i_y[i] ^ w_c[i];
            w_c[i+1]  = (i_x[i] & i_y[i]) | (w_c[i] & (i_x[i] ^ i_y[i]));
        end
        o_cout = w_c[4];
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WORDS=4) with an arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 4 * WORDS;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    nibble_serial_adder_ctrl_if #(.WORDS(WORDS)) bus ();

    nibble_serial_adder_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                                  output logic [W-1:0] s, output logic c, output logic v);
        longint full;
        longint sa;
        longint sb;
        longint sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            full = longint'(a) + longint'(b);
            sr   = sa + sb;
        end else begin
            full = longint'(a) + (longint'(1) << W) - longint'(b);
            sr   = sa - sb;
        end
        s = W'(full);
        c = (full >= (longint'(1) << W));
        v = (sr > 32767) || (sr < -32768);
    endfunction

    // Present one request at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_;
        bus.op    = top;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.op    = 1'($urandom);
    endtask

    // Wait (bounded) for done; counts busy-high and ready-low cycles seen before it.
    task automatic wait_done(output int lat, output int busy_cnt, output int rdy_low_cnt);
        lat         = -1;
        busy_cnt    = (bus.busy === 1'b1) ? 1 : 0;
        rdy_low_cnt = (bus.ready === 1'b0) ? 1 : 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy === 1'b1)  busy_cnt++;
            if (bus.ready === 1'b0) rdy_low_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        n_cmp++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.sum   !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
        n_cmp++; if (bus.cout  !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", bus.cout); end
        n_cmp++; if (bus.ovf   !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
        logic [W-1:0] tb_[5] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
        logic         to [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] es [5] = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic         ev [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, bc, rc;
        for (int i = 0; i < 5; i++) begin
            issue(ta[i], tb_[i], to[i]);
            wait_done(lat, bc, rc);
            n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
            n_cmp++; if (bus.sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum got=%h exp=%h", i, bus.sum, es[i]); end
            n_cmp++; if (bus.cout !== ec[i]) begin n_fail++; $display("FAIL dir%0d_cout got=%b exp=%b", i, bus.cout, ec[i]); end
            n_cmp++; if (bus.ovf !== ev[i]) begin n_fail++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, bus.ovf, ev[i]); end
            n_cmp++; if (bc !== 4) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d exp=4", i, bc); end
            n_cmp++; if (rc !== 4) begin n_fail++; $display("FAIL dir%0d_ready_low_cycles got=%0d exp=4", i, rc); end
            n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_ready_in_done got=%b exp=1", i, bus.ready); end
            @(negedge clk);
            n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b exp=0", i, bus.done); end
            n_cmp++; if (bus.sum !== es[i]) begin n_fail++; $display("FAIL dir%0d_sum_hold got=%h exp=%h", i, bus.sum, es[i]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, es;
        logic         ro, ec, ev;
        int lat, bc, rc;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ro = 1'($urandom);
            if (i % 8 == 3) rb = ra;
            if (i % 8 == 5) ra = 16'h8000;
            model(ra, rb, ro, es, ec, ev);
            issue(ra, rb, ro);
            wait_done(lat, bc, rc);
            n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rnd%0d_latency got=%0d exp=4", i, lat); end
            n_cmp++; if (bus.sum !== es) begin n_fail++; $display("FAIL rnd%0d_sum a=%h b=%h op=%b got=%h exp=%h", i, ra, rb, ro, bus.sum, es); end
            n_cmp++; if (bus.cout !== ec) begin n_fail++; $display("FAIL rnd%0d_cout a=%h b=%h op=%b got=%b exp=%b", i, ra, rb, ro, bus.cout, ec); end
            n_cmp++; if (bus.ovf !== ev) begin n_fail++; $display("FAIL rnd%0d_ovf a=%h b=%h op=%b got=%b exp=%b", i, ra, rb, ro, bus.ovf, ev); end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_run_ignore();
        int lat;
        issue(16'h1234, 16'h0FFF, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.op    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int n = 3; n <= 12; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = n; break; end
        end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL ign_latency got=%0d exp=4", lat); end
        n_cmp++; if (bus.sum !== 16'h2233) begin n_fail++; $display("FAIL ign_sum got=%h exp=2233", bus.sum); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL ign_cout got=%b exp=0", bus.cout); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ign_no_second_op got=%b exp=0", bus.busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bc, rc, unstable;
        issue(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat, bc, rc);
        n_cmp++; if (bus.sum !== 16'h8000) begin n_fail++; $display("FAIL b2b_first_sum got=%h exp=8000", bus.sum); end
        bus.start = 1'b1;
        bus.a     = 16'h0001;
        bus.b     = 16'h0001;
        bus.op    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.busy); end
        lat      = -1;
        unstable = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin lat = n; break; end
            if (bus.sum !== 16'h8000) unstable++;
        end
        n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL b2b_sum_stable got=%0d changed cycles exp=0", unstable); end
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
        n_cmp++; if (bus.sum !== 16'h0002) begin n_fail++; $display("FAIL b2b_sum got=%h exp=0002", bus.sum); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got=%b exp=0", bus.ovf); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bc, rc, seen;
        issue(16'h1234, 16'h0FFF, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b exp=1", bus.ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
        n_cmp++; if (bus.sum !== 16'h0000) begin n_fail++; $display("FAIL rstmid_sum got=%h exp=0000", bus.sum); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL rstmid_cout got=%b exp=0", bus.cout); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf got=%b exp=0", bus.ovf); end
        rst_n = 1'b1;
        seen  = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", seen); end
        issue(16'h8000, 16'h0001, 1'b1);
        wait_done(lat, bc, rc);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL rstmid_after_latency got=%0d exp=4", lat); end
        n_cmp++; if (bus.sum !== 16'h7FFF) begin n_fail++; $display("FAIL rstmid_after_sum got=%h exp=7fff", bus.sum); end
        n_cmp++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_ovf got=%b exp=1", bus.ovf); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_random();
        test_run_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
